dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//   Responder side of the CPU data-memory port. Serves dmem_read/dmem_write with a word RAM
//   and an MMIO window holding a UART transmitter (TX FIFO + serializer) and a cycle counter.
//   Sits beside the core at top level; rdata is combinational to meet the single-cycle datapath.
// PARAMETERS
//   RAM_WORDS     1024           RAM depth in 32-bit words (power of 2)
//   FIFO_DEPTH    4              TX FIFO entries (power of 2, >=2)
//   CLKS_PER_BIT  4              clk cycles per UART bit (>=1)
//   MMIO_BASE     32'h8000_0000  base of MMIO window (4 KiB)
// PORTS
//   clk         in   1   clock, all state updates on posedge
//   reset       in   1   synchronous, active-high
//   dmem_write  in   1   write strobe, committed on posedge
//   dmem_read   in   1   read strobe (rdata valid same cycle)
//   dmem_addr   in   32  byte address; addr[1:0] ignored (word access only)
//   dmem_wdata  in   32  write data
//   dmem_rdata  out  32  read data, combinational from addr
//   uart_tx     out  1   serial output, idle high
//   tx_busy     out  1   serializer not IDLE
// BEHAVIOUR
//   Reset: uart_tx=1, tx_busy=0, FIFO empty, overflow=0, cycle=0, state IDLE. RAM not cleared.
//   Reset mid-frame aborts frame; uart_tx=1 from the cycle after the reset edge.
//   Decode: RAM if addr < RAM_WORDS*4; MMIO if addr[31:12]==MMIO_BASE[31:12]; else unmapped.
//   rdata = 0 unless dmem_read; unmapped reads -> 0, unmapped writes ignored.
//   RAM: rdata=mem[addr[..:2]] combinational; write at posedge. Same-cycle read returns old word.
//   MMIO offsets:
//     0x00 TXDATA  W: push wdata[7:0] into FIFO; R: 0
//     0x04 STATUS  R: {28'b0, overflow, tx_busy, empty, full}; W: any write clears overflow
//     0x08 CYCLE   R: free-running 32-bit counter; W: counter<=0 on that edge (wins over incr)
//     other        R: 0, W: ignored
//   Both strobes high (illegal from core): write side effects happen, rdata still driven.
//   Counter: +1 every non-reset edge, wraps 0xFFFF_FFFF -> 0.
//   FIFO: push when TXDATA write and not full; push when full dropped, overflow<=1 (sticky).
//     Pop and push same edge allowed, incl. when full (pop frees slot first -> push accepted).
//     Pointers log2(FIFO_DEPTH)+1 bits, wrap naturally; full/empty from MSB compare.
//   Serializer FSM, bit timer counts CLKS_PER_BIT-1..0:
//     IDLE : uart_tx=1; if FIFO !empty: pop into shift reg -> START
//     START: uart_tx=0 for CLKS_PER_BIT cycles -> DATA
//     DATA : 8 bits LSB first, CLKS_PER_BIT each, bit index 0..7 -> STOP
//     STOP : uart_tx=1 for CLKS_PER_BIT cycles -> IDLE (next byte may start next edge)
//   Latency: push at edge N into empty FIFO/IDLE -> pop at N+1, start bit from N+1 to N+1+CPB.
//   Frame = 10*CLKS_PER_BIT cycles; back-to-back frames have one IDLE cycle between.
//   uart_tx is a registered output (no glitches).
// TESTING
//   1 wr 0xDEADBEEF @0x10; rd 0x10 and 0x13 next cycle -> 0xDEADBEEF both; rd 0x5000_0000 -> 0.
//   2 CPB=4, wr 0x41 @TXDATA -> uart_tx 0x4 cyc, bits 1,0,0,0,0,0,1,0 x4 cyc, stop 1; 40 cyc total.
//   3 6 TXDATA wr back-to-back, idle tx -> STATUS full=1,overflow=1; bytes 1-5 emerge, 6th lost.
//   4 wr STATUS -> overflow=0; rd MMIO+0x0C -> 0; wr MMIO+0x0C no effect.
//   5 10 edges after reset release, rd CYCLE -> 10; wr CYCLE, rd one edge later -> 1.
//   6 reset 3 bits into frame -> uart_tx=1, STATUS=0x2 next cycle; RAM word @0x10 preserved.

Source files
------------

// File: rtl/dmem_if.sv
// Data-memory port bundle between the CPU core (master) and the memory/MMIO responder (slave).
interface dmem_if;
    logic        dmem_write;
    logic        dmem_read;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_write,
        output dmem_read,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_write,
        input  dmem_read,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus an MMIO window with a UART transmitter
// (TX FIFO + serializer) and a free-running cycle counter. Read data is combinational.
module dmem_responder #(
    parameter int          RAM_WORDS    = 1024,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          CLKS_PER_BIT = 4,
    parameter logic [31:0] MMIO_BASE    = 32'h8000_0000
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus,
    output logic   uart_tx,
    output logic   tx_busy
);

    localparam int             AW        = $clog2(RAM_WORDS);
    localparam int             PW        = $clog2(FIFO_DEPTH);
    localparam int             TW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]  BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]  BIT_ZERO  = TW'(0);
    localparam logic [TW-1:0]  BIT_ONE   = TW'(1);
    localparam logic [PW:0]    PTR_ONE   = (PW + 1)'(1);
    localparam logic [32:0]    RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    logic [31:0]   mem_r [RAM_WORDS];
    logic [7:0]    fifo_r [FIFO_DEPTH];
    logic [PW:0]   wr_ptr_r, rd_ptr_r;
    logic          overflow_r;
    logic [31:0]   cycle_r;

    tx_state_e     state_r, state_s;
    logic [TW-1:0] timer_r, timer_s;
    logic [2:0]    bit_idx_r, bit_idx_s;
    logic [7:0]    shift_r, shift_s;
    logic          uart_tx_r, uart_tx_s;
    logic          tx_busy_r;

    logic          ram_hit_s, mmio_hit_s;
    logic [9:0]    reg_off_s;
    logic [AW-1:0] ram_idx_s;
    logic          wr_txdata_s, wr_status_s, wr_cycle_s;
    logic          empty_s, full_s, pop_s, push_s;
    logic [31:0]   status_s;

    // Address decode and FIFO handshake terms shared by read and write paths.
    always_comb begin
        ram_hit_s   = ({1'b0, bus.dmem_addr} < RAM_BYTES);
        mmio_hit_s  = (bus.dmem_addr[31:12] == MMIO_BASE[31:12]);
        reg_off_s   = bus.dmem_addr[11:2];
        ram_idx_s   = bus.dmem_addr[AW+1:2];
        wr_txdata_s = bus.dmem_write && mmio_hit_s && (reg_off_s == 10'd0);
        wr_status_s = bus.dmem_write && mmio_hit_s && (reg_off_s == 10'd1);
        wr_cycle_s  = bus.dmem_write && mmio_hit_s && (reg_off_s == 10'd2);
        empty_s     = (wr_ptr_r == rd_ptr_r);
        full_s      = (wr_ptr_r[PW] != rd_ptr_r[PW]) && (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
        // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
        pop_s       = (state_r == S_IDLE) && !empty_s;
        push_s      = wr_txdata_s && (!full_s || pop_s);
        status_s    = {28'd0, overflow_r, tx_busy_r, empty_s, full_s};
    end

    // Combinational read mux; zero whenever the read strobe is low or nothing decodes.
    always_comb begin
        bus.dmem_rdata = 32'd0;
        if (!bus.dmem_read) begin
            bus.dmem_rdata = 32'd0;
        end else if (ram_hit_s) begin
            bus.dmem_rdata = mem_r[ram_idx_s];
        end else if (mmio_hit_s) begin
            case (reg_off_s)
                10'd1:   bus.dmem_rdata = status_s;
                10'd2:   bus.dmem_rdata = cycle_r;
                default: bus.dmem_rdata = 32'd0;
            endcase
        end else begin
            bus.dmem_rdata = 32'd0;
        end
    end

    // RAM and FIFO storage arrays; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (bus.dmem_write && ram_hit_s) begin
            mem_r[ram_idx_s] <= bus.dmem_wdata;
        end
        if (!reset && push_s) begin
            fifo_r[wr_ptr_r[PW-1:0]] <= bus.dmem_wdata[7:0];
        end
    end

    // FIFO pointers, sticky overflow flag and cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {(PW+1){1'b0}};
            rd_ptr_r   <= {(PW+1){1'b0}};
            overflow_r <= 1'b0;
            cycle_r    <= 32'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (wr_txdata_s && !push_s) begin
                overflow_r <= 1'b1;
            end else if (wr_status_s) begin
                overflow_r <= 1'b0;
            end
            cycle_r <= wr_cycle_s ? 32'd0 : (cycle_r + 32'd1);
        end
    end

    // Serializer next-state: start bit, 8 data bits LSB first, stop bit.
    always_comb begin
        state_s   = state_r;
        timer_s   = timer_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        uart_tx_s = uart_tx_r;
        case (state_r)
            S_IDLE: begin
                uart_tx_s = 1'b1;
                if (!empty_s) begin
                    shift_s   = fifo_r[rd_ptr_r[PW-1:0]];
                    timer_s   = BIT_LAST;
                    state_s   = S_START;
                    uart_tx_s = 1'b0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_START: begin
                if (timer_r == BIT_ZERO) begin
                    state_s   = S_DATA;
                    timer_s   = BIT_LAST;
                    bit_idx_s = 3'd0;
                    uart_tx_s = shift_r[0];
                end else begin
                    timer_s = timer_r - BIT_ONE;
                end
            end
            S_DATA: begin
                if (timer_r == BIT_ZERO) begin
                    timer_s = BIT_LAST;
                    if (bit_idx_r == 3'd7) begin
                        state_s   = S_STOP;
                        uart_tx_s = 1'b1;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                        shift_s   = {1'b0, shift_r[7:1]};
                        uart_tx_s = shift_r[1];
                    end
                end else begin
                    timer_s = timer_r - BIT_ONE;
                end
            end
            S_STOP: begin
                if (timer_r == BIT_ZERO) begin
                    state_s   = S_IDLE;
                    uart_tx_s = 1'b1;
                end else begin
                    timer_s = timer_r - BIT_ONE;
                end
            end
            default: begin
                state_s   = S_IDLE;
                uart_tx_s = 1'b1;
            end
        endcase
    end

    // Serializer state register; uart_tx and tx_busy come straight from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            timer_r   <= BIT_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            uart_tx_r <= 1'b1;
            tx_busy_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            bit_idx_r <= bit_idx_s;
            shift_r   <= shift_s;
            uart_tx_r <= uart_tx_s;
            tx_busy_r <= (state_s != S_IDLE);
        end
    end

    assign uart_tx = uart_tx_r;
    assign tx_busy = tx_busy_r;

endmodule
